pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised elastic pipeline register between adjacent CPU stages (IF->ID, ID->EX, ...).
//  Carries instruction word + PC with valid/ready handshake, synchronous flush and bubble insertion.
//  Replaces the fixed 32-bit enable-only stage register.
//  Stall comes from downstream backpressure (out_ready=0) instead of a bare enable.
// PARAMETERS
//  INSTR_W    32            instruction field width
//  PC_W       32            PC field width
//  NOP_INSTR  32'h0000_0000 instruction value driven whenever the stage holds a bubble
//  PC_RESET   32'h0000_0000 out_pc value after reset
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        synchronous, active-high
//  flush      in   1        kill all held entries this cycle (branch/exception redirect)
//  in_valid   in   1        upstream offers in_instr/in_pc
//  in_ready   out  1        stage accepts this cycle; transfer = in_valid & in_ready
//  in_instr   in   INSTR_W  upstream instruction
//  in_pc      in   PC_W     upstream PC
//  out_valid  out  1        out_instr/out_pc hold a live instruction
//  out_ready  in   1        downstream accepts; transfer = out_valid & out_ready
//  out_instr  out  INSTR_W  NOP_INSTR when out_valid=0
//  out_pc     out  PC_W     PC of held entry; retains last value during bubbles
//  occupancy  out  2        live entries held (0..1, or 0..2 with skid)
// BEHAVIOUR
//  - Reset (sync, active-high): out_valid=0, out_instr=NOP_INSTR, out_pc=PC_RESET, occupancy=0,
//    all internal valids cleared. reset has priority over flush and handshakes.
//  - Latency: an accepted input appears on out_* at the next rising edge (1 cycle).
//  - Stability: while out_valid=1 & out_ready=0, out_instr/out_pc/out_valid are held unchanged.
//  - Once asserted, in_valid must stay high until accepted. The block must not depend on this.
//  - Base mode (no skid): in_ready = ~out_valid | out_ready. The path is combinational from out_ready.
//    Simultaneous accept+drain loads the new entry, so full throughput is 1/cycle.
//  - Drain without accept: out_valid<=0 and out_instr<=NOP_INSTR. out_pc is held.
//  - flush=1: every held entry is invalidated at the edge.
//    Any same-cycle input is discarded even if in_ready=1.
//    out_instr<=NOP_INSTR and occupancy<=0. in_ready is unaffected by flush.
//  - A downstream transfer in the flush cycle still counts for the consumer.
//    The entry is simply not replaced.
//  - occupancy updates on the same edge as out_valid/skid valid.
//    It equals the sum of the internal valid bits.
// CONFIGURATION
//  PIPE_SKID_BUFFER_EN defined:
//    - Adds a second (skid) entry. in_ready is a registered flop = ~skid_valid.
//      There is no combinational ready path.
//    - Main entry occupied, out_ready=0, input accepted: input goes to skid, occupancy=2,
//      and in_ready<=0 next cycle.
//    - Main entry drains while skid is valid: skid moves to main and in_ready<=1.
//    - Order is preserved: main is always older than skid.
//    - flush clears both entries and sets in_ready<=1.
//  PIPE_SKID_BUFFER_EN undefined:
//    - Single-entry base mode as above. Skid logic and flops are absent.
//    - occupancy[1] is tied 0.
// TESTING
//  1. Reset for 2 cycles then release -> out_valid=0, out_instr=NOP_INSTR, out_pc=0, in_ready=1.
//  2. Stream instr 0x0001_0093/0x0002_0113/0x0003_0193 at PC 0x00,0x04,0x08 with out_ready=1
//     -> same sequence out 1 cycle later, back-to-back, no bubbles.
//  3. Load PC 0x10, hold out_ready=0 for 3 cycles -> out_pc=0x10 stable.
//     Base mode: in_ready=0 throughout. Skid mode: one more entry (PC 0x14) accepted, then in_ready=0.
//  4. Occupied stage plus in_valid=1, flush=1 in the same cycle -> next cycle out_valid=0,
//     out_instr=NOP_INSTR, occupancy=0, input PC not seen at the output.
//  5. Skid mode with occupancy=2 (PC 0x20,0x24), raise out_ready
//     -> PC 0x20 then PC 0x24 on consecutive cycles, in_ready=1 after the first drain.
//  6. reset asserted while occupancy>0 and flush=1 -> reset values next cycle, no entry leaks out.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register between CPU stages: instruction + PC with valid/ready, flush and bubbles.
// Define PIPE_SKID_BUFFER_EN to add a second (skid) entry and a fully registered in_ready_o.
module pipe_stage_reg #(
   parameter int                 INSTR_W   = 32,
   parameter int                 PC_W      = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
   parameter logic [PC_W-1:0]    PC_RESET  = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [INSTR_W-1:0] in_instr_i,
   input  logic [PC_W-1:0]    in_pc_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [INSTR_W-1:0] out_instr_o,
   output logic [PC_W-1:0]    out_pc_o,
   output logic [1:0]         occupancy_o
);

   logic               mainValid_q, mainValid_d;
   logic [INSTR_W-1:0] mainInstr_q, mainInstr_d;
   logic [PC_W-1:0]    mainPc_q, mainPc_d;
   logic               inAccept;
   logic               outDrain;

   assign outDrain    = mainValid_q & out_ready_i;
   assign out_valid_o = mainValid_q;
   assign out_instr_o = mainInstr_q;
   assign out_pc_o    = mainPc_q;

`ifdef PIPE_SKID_BUFFER_EN

   logic               skidValid_q, skidValid_d;
   logic [INSTR_W-1:0] skidInstr_q, skidInstr_d;
   logic [PC_W-1:0]    skidPc_q, skidPc_d;
   logic               inReady_q, inReady_d;

   // inReady_q always mirrors ~skidValid_q, so an accept can never coincide with a full skid
   assign in_ready_o  = inReady_q;
   assign inAccept    = in_valid_i & inReady_q;
   assign occupancy_o = {1'b0, mainValid_q} + {1'b0, skidValid_q};

   always_comb begin
      mainValid_d = mainValid_q;
      mainInstr_d = mainInstr_q;
      mainPc_d    = mainPc_q;
      skidValid_d = skidValid_q;
      skidInstr_d = skidInstr_q;
      skidPc_d    = skidPc_q;
      if (flush_i) begin
         mainValid_d = 1'b0;
         mainInstr_d = NOP_INSTR;
         skidValid_d = 1'b0;
      end else if (!mainValid_q) begin
         if (inAccept) begin
            mainValid_d = 1'b1;
            mainInstr_d = in_instr_i;
            mainPc_d    = in_pc_i;
         end
      end else if (outDrain) begin
         if (skidValid_q) begin
            mainInstr_d = skidInstr_q;
            mainPc_d    = skidPc_q;
            skidValid_d = 1'b0;
         end else if (inAccept) begin
            mainInstr_d = in_instr_i;
            mainPc_d    = in_pc_i;
         end else begin
            mainValid_d = 1'b0;
            mainInstr_d = NOP_INSTR;
         end
      end else if (inAccept) begin
         skidValid_d = 1'b1;
         skidInstr_d = in_instr_i;
         skidPc_d    = in_pc_i;
      end
      inReady_d = ~skidValid_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mainValid_q <= 1'b0;
         mainInstr_q <= NOP_INSTR;
         mainPc_q    <= PC_RESET;
         skidValid_q <= 1'b0;
         skidInstr_q <= NOP_INSTR;
         skidPc_q    <= PC_RESET;
         inReady_q   <= 1'b1;
      end else begin
         mainValid_q <= mainValid_d;
         mainInstr_q <= mainInstr_d;
         mainPc_q    <= mainPc_d;
         skidValid_q <= skidValid_d;
         skidInstr_q <= skidInstr_d;
         skidPc_q    <= skidPc_d;
         inReady_q   <= inReady_d;
      end
   end

`else

   // Ready passes straight through from downstream so accept and drain can share a cycle
   assign in_ready_o  = ~mainValid_q | out_ready_i;
   assign inAccept    = in_valid_i & in_ready_o;
   assign occupancy_o = {1'b0, mainValid_q};

   always_comb begin
      mainValid_d = mainValid_q;
      mainInstr_d = mainInstr_q;
      mainPc_d    = mainPc_q;
      if (flush_i) begin
         mainValid_d = 1'b0;
         mainInstr_d = NOP_INSTR;
      end else if (inAccept) begin
         mainValid_d = 1'b1;
         mainInstr_d = in_instr_i;
         mainPc_d    = in_pc_i;
      end else if (outDrain) begin
         mainValid_d = 1'b0;
         mainInstr_d = NOP_INSTR;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mainValid_q <= 1'b0;
         mainInstr_q <= NOP_INSTR;
         mainPc_q    <= PC_RESET;
      end else begin
         mainValid_q <= mainValid_d;
         mainInstr_q <= mainInstr_d;
         mainPc_q    <= mainPc_d;
      end
   end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed scenarios plus random traffic against a queue model.
// Follows PIPE_SKID_BUFFER_EN to pick the expected capacity (1 or 2 entries).
module tb_pipe_stage_reg;

   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] PC_RST   = 32'h0000_0000;
`ifdef PIPE_SKID_BUFFER_EN
   localparam int          CAP      = 2;
`else
   localparam int          CAP      = 1;
`endif

   logic        clk = 1'b0;
   logic        reset, flush, inValid, inReady, outValid, outReady;
   logic [31:0] inInstr, inPc, outInstr, outPc;
   logic [1:0]  occupancy;
   int          total = 0;
   int          bad = 0;

   // Reference model: FIFO of held entries (front is on the output) plus the last shown PC
   logic [31:0] qInstr[$];
   logic [31:0] qPc[$];
   logic [31:0] mPc = PC_RST;

   pipe_stage_reg #(
      .INSTR_W(32), .PC_W(32), .NOP_INSTR(NOP), .PC_RESET(PC_RST)
   ) dut (
      .clk(clk), .reset(reset), .flush_i(flush),
      .in_valid_i(inValid), .in_ready_o(inReady), .in_instr_i(inInstr), .in_pc_i(inPc),
      .out_valid_o(outValid), .out_ready_i(outReady), .out_instr_o(outInstr),
      .out_pc_o(outPc), .occupancy_o(occupancy)
   );

   always #5 clk = ~clk;

   function automatic bit modelReady();
      if (CAP == 2) return qPc.size() < 2;
      return (qPc.size() == 0) || outReady;
   endfunction

   // Advance the model by one edge with the current inputs, then step the clock
   task automatic tick();
      bit acc, drn;
      acc = inValid && modelReady();
      drn = (qPc.size() > 0) && outReady;
      if (reset) begin
         qInstr.delete(); qPc.delete(); mPc = PC_RST;
      end else if (flush) begin
         qInstr.delete(); qPc.delete();
      end else begin
         if (drn) begin void'(qInstr.pop_front()); void'(qPc.pop_front()); end
         if (acc) begin qInstr.push_back(inInstr); qPc.push_back(inPc); end
      end
      if (qPc.size() > 0) mPc = qPc[0];
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] pc);
      inValid = 1'b1;
      inPc    = pc;
      inInstr = 32'hA000_0000 | pc;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
      inInstr = '0; inPc = '0;
      tick(); tick();
      reset = 1'b0;
      #1;
      total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got %b want 0", outValid); end
      total++; if (outInstr !== NOP) begin bad++; $display("[TB] FAIL reset_instr got %h want %h", outInstr, NOP); end
      total++; if (outPc !== PC_RST) begin bad++; $display("[TB] FAIL reset_pc got %h want %h", outPc, PC_RST); end
      total++; if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got %b want 1", inReady); end
      total++; if (occupancy !== 2'd0) begin bad++; $display("[TB] FAIL reset_occ got %0d want 0", occupancy); end
   endtask

   task automatic test_stream();
      logic [31:0] ins[3];
      ins[0] = 32'h0001_0093; ins[1] = 32'h0002_0113; ins[2] = 32'h0003_0193;
      outReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         inValid = 1'b1; inInstr = ins[i]; inPc = 32'(i * 4);
         #1;
         total++; if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL stream_ready[%0d] got %b want 1", i, inReady); end
         tick();
         total++; if (outValid !== 1'b1 || outInstr !== ins[i] || outPc !== 32'(i * 4))
            begin bad++; $display("[TB] FAIL stream_out[%0d] got v=%b %h@%h want v=1 %h@%h", i, outValid, outInstr, outPc, ins[i], i * 4); end
      end
      inValid = 1'b0;
      tick();
      total++; if (outValid !== 1'b0 || outInstr !== NOP) begin bad++; $display("[TB] FAIL stream_end got v=%b %h want v=0 %h", outValid, outInstr, NOP); end
   endtask

   task automatic test_stall();
      outReady = 1'b1; offer(32'h10);
      tick();
      outReady = 1'b0; offer(32'h14);
      for (int k = 0; k < 3; k++) begin
         #1;
         total++; if (inReady !== (CAP == 2 && k == 0)) begin bad++; $display("[TB] FAIL stall_ready[%0d] got %b want %b", k, inReady, (CAP == 2 && k == 0)); end
         total++; if (outValid !== 1'b1 || outPc !== 32'h10) begin bad++; $display("[TB] FAIL stall_hold[%0d] got v=%b pc=%h want v=1 pc=10", k, outValid, outPc); end
         tick();
      end
      total++; if (occupancy !== 2'(CAP)) begin bad++; $display("[TB] FAIL stall_occ got %0d want %0d", occupancy, CAP); end
      inValid = 1'b0; outReady = 1'b1;
      tick();
      total++; if (outValid !== (CAP == 2) || outPc !== (CAP == 2 ? 32'h14 : 32'h10))
         begin bad++; $display("[TB] FAIL stall_drain got v=%b pc=%h", outValid, outPc); end
      tick();
      total++; if (occupancy !== 2'd0) begin bad++; $display("[TB] FAIL stall_empty got %0d want 0", occupancy); end
   endtask

   task automatic test_flush();
      outReady = 1'b0; offer(32'h40);
      tick();
      flush = 1'b1; offer(32'h44);
      #1;
      total++; if (inReady !== (CAP == 2)) begin bad++; $display("[TB] FAIL flush_ready got %b want %b", inReady, CAP == 2); end
      tick();
      flush = 1'b0; inValid = 1'b0;
      #1;
      total++; if (outValid !== 1'b0 || outInstr !== NOP || occupancy !== 2'd0)
         begin bad++; $display("[TB] FAIL flush_kill got v=%b %h occ=%0d want v=0 %h occ=0", outValid, outInstr, occupancy, NOP); end
      total++; if (outPc !== 32'h40) begin bad++; $display("[TB] FAIL flush_pc got %h want 40", outPc); end
      outReady = 1'b1; offer(32'h50);
      tick();
      flush = 1'b1; offer(32'h54);
      #1;
      total++; if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL flush_ready2 got %b want 1", inReady); end
      tick();
      flush = 1'b0; inValid = 1'b0;
      #1;
      total++; if (outValid !== 1'b0 || outPc !== 32'h50) begin bad++; $display("[TB] FAIL flush_discard got v=%b pc=%h want v=0 pc=50", outValid, outPc); end
   endtask

   task automatic test_back_to_back();
      outReady = 1'b0; offer(32'h20);
      tick();
      offer(32'h24);
      #1;
      total++; if (inReady !== (CAP == 2)) begin bad++; $display("[TB] FAIL b2b_ready0 got %b want %b", inReady, CAP == 2); end
`ifdef PIPE_SKID_BUFFER_EN
      tick();
      inValid = 1'b0;
      #1;
      total++; if (occupancy !== 2'd2 || inReady !== 1'b0 || outPc !== 32'h20)
         begin bad++; $display("[TB] FAIL b2b_full got occ=%0d rdy=%b pc=%h want occ=2 rdy=0 pc=20", occupancy, inReady, outPc); end
      outReady = 1'b1;
`else
      outReady = 1'b1;
      #1;
      total++; if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL b2b_comb_ready got %b want 1", inReady); end
`endif
      tick();
      inValid = 1'b0;
      #1;
      total++; if (outValid !== 1'b1 || outPc !== 32'h24 || inReady !== 1'b1 || occupancy !== 2'd1)
         begin bad++; $display("[TB] FAIL b2b_second got v=%b pc=%h rdy=%b occ=%0d want v=1 pc=24 rdy=1 occ=1", outValid, outPc, inReady, occupancy); end
      tick();
      total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_empty got %b want 0", outValid); end
   endtask

   task automatic test_reset_flush();
      outReady = 1'b0; offer(32'h30);
      tick();
      offer(32'h34);
      tick();
      reset = 1'b1; flush = 1'b1; offer(32'h38);
      tick();
      reset = 1'b0; flush = 1'b0; inValid = 1'b0;
      #1;
      total++; if (outValid !== 1'b0 || outInstr !== NOP || outPc !== PC_RST || occupancy !== 2'd0 || inReady !== 1'b1)
         begin bad++; $display("[TB] FAIL rstflush got v=%b %h pc=%h occ=%0d rdy=%b", outValid, outInstr, outPc, occupancy, inReady); end
      outReady = 1'b1;
      tick();
      total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL rstflush_leak got %b want 0", outValid); end
   endtask

   task automatic test_random();
      logic [31:0] expInstr;
      reset = 1'b1; flush = 1'b0; inValid = 1'b0;
      tick();
      reset = 1'b0;
      for (int c = 0; c < 600; c++) begin
         reset    = ($urandom_range(0, 79) == 0);
         flush    = ($urandom_range(0, 15) == 0);
         outReady = ($urandom_range(0, 3) != 0);
         inValid  = ($urandom_range(0, 3) != 0);
         inInstr  = $urandom;
         inPc     = $urandom & 32'hFFFF_FFFC;
         #1;
         expInstr = (qInstr.size() > 0) ? qInstr[0] : NOP;
         total++; if (inReady !== modelReady()) begin bad++; $display("[TB] FAIL rnd_ready c=%0d got %b want %b", c, inReady, modelReady()); end
         total++; if (outValid !== (qPc.size() > 0)) begin bad++; $display("[TB] FAIL rnd_valid c=%0d got %b want %b", c, outValid, qPc.size() > 0); end
         total++; if (outInstr !== expInstr) begin bad++; $display("[TB] FAIL rnd_instr c=%0d got %h want %h", c, outInstr, expInstr); end
         total++; if (outPc !== mPc) begin bad++; $display("[TB] FAIL rnd_pc c=%0d got %h want %h", c, outPc, mPc); end
         total++; if (occupancy !== 2'(qPc.size())) begin bad++; $display("[TB] FAIL rnd_occ c=%0d got %0d want %0d", c, occupancy, qPc.size()); end
         tick();
      end
      reset = 1'b0; flush = 1'b0; inValid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_flush();
      test_back_to_back();
      test_reset_flush();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
